sync_fifo_ctrl: RTL and testbench

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

---
 rtl/sync_fifo_ctrl.sv | 135 +++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: pointer, occupancy and status logic for an external 1R1W RAM
// with a one-cycle registered read. Optional almost_full/almost_empty flags via ALMOST_FLAGS_EN.
module sync_fifo_ctrl #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              write,
  output logic              read,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              rd_valid,
  output logic              overflow,
`ifdef ALMOST_FLAGS_EN
  output logic              almost_full,
  output logic              almost_empty,
`endif
  output logic              underflow
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);

  // Reject parameter sets the pointer arithmetic cannot support.
  if (((1 << ADDR_W) != DEPTH) || (AF_LEVEL > DEPTH) || (AE_LEVEL > DEPTH)) begin : g_param_check
    $error("sync_fifo_ctrl: DEPTH must equal 2**ADDR_W and flag levels must not exceed DEPTH");
  end

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              full_r;
  logic              empty_r;
  logic              rd_valid_r;
  logic              overflow_r;
  logic              underflow_r;
  logic              write_s;
  logic              read_s;
  logic [ADDR_W:0]   count_nxt_s;

  // Accept/reject decisions and next occupancy.
  always_comb begin
    write_s     = 1'b0;
    read_s      = 1'b0;
    count_nxt_s = count_r;
    if (rst) begin
      write_s = 1'b0;
      read_s  = 1'b0;
    end else begin
      write_s = wr_en & ~full_r;
      read_s  = rd_en & ~empty_r;
    end
    case ({write_s, read_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and status flags; flags derive from the next count so they never lag it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      rd_valid_r  <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (write_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (read_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r     <= count_nxt_s;
      full_r      <= (count_nxt_s == FULL_CNT);
      empty_r     <= (count_nxt_s == CNT_ZERO);
      rd_valid_r  <= read_s;
      overflow_r  <= wr_en & full_r;
      underflow_r <= rd_en & empty_r;
    end
  end

`ifdef ALMOST_FLAGS_EN
  localparam logic [ADDR_W:0] AF_CNT = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT = (ADDR_W+1)'(AE_LEVEL);

  logic almost_full_r;
  logic almost_empty_r;

  // Threshold flags, registered from the same next count as full/empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
    end else begin
      almost_full_r  <= (count_nxt_s >= AF_CNT);
      almost_empty_r <= (count_nxt_s <= AE_CNT);
    end
  end

  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;
`endif

  assign write     = write_s;
  assign read      = read_s;
  assign wr_addr   = wr_ptr_r;
  assign rd_addr   = rd_ptr_r;
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;
  assign rd_valid  = rd_valid_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl with a behavioural 1R1W RAM (registered read).
// Define ALMOST_FLAGS_EN to also exercise the almost_full/almost_empty flags.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       write, read, full, empty, rd_valid, overflow, underflow;
  logic [3:0] wr_addr, rd_addr;
  logic [4:0] count;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] ram_q;
  logic [7:0] mem [16];
`ifdef ALMOST_FLAGS_EN
  logic       almost_full, almost_empty;
`endif

  int checks = 0;
  int errors = 0;

  sync_fifo_ctrl #(.DEPTH(16), .ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .write(write), .read(read), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .full(full), .empty(empty), .count(count), .rd_valid(rd_valid),
    .overflow(overflow),
`ifdef ALMOST_FLAGS_EN
    .almost_full(almost_full), .almost_empty(almost_empty),
`endif
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // RAM model driven by the controller strobes
  always @(posedge clk) begin
    if (write) mem[wr_addr] <= wr_data;
    if (read) ram_q <= mem[rd_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_data = 8'(base + i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    #1;
    checks++; if (write !== 1'b0 || read !== 1'b0) begin errors++; $display("FAIL reset_strobes write=%b read=%b expected 0 0", write, read); end
    step();
    checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_state count=%0d empty=%b full=%b expected 0 1 0", count, empty, full); end
    checks++; if (wr_addr !== 4'd0 || rd_addr !== 4'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL reset_regs wa=%0d ra=%0d rv=%b ov=%b un=%b expected all 0", wr_addr, rd_addr, rd_valid, overflow, underflow);
    end
`ifdef ALMOST_FLAGS_EN
    checks++; if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost af=%b ae=%b expected 0 1", almost_full, almost_empty); end
`endif
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      #1;
      checks++; if (write !== 1'b1 || wr_addr !== 4'(i)) begin errors++; $display("FAIL fill_push%0d write=%b wr_addr=%0d expected 1 %0d", i, write, wr_addr, i); end
      step();
      checks++; if (count !== 5'(i + 1) || overflow !== 1'b0) begin errors++; $display("FAIL fill_count%0d count=%0d ov=%b expected %0d 0", i, count, overflow, i + 1); end
    end
    wr_en = 1'b0;
    checks++; if (full !== 1'b1 || empty !== 1'b0 || count !== 5'd16) begin errors++; $display("FAIL fill_full full=%b empty=%b count=%0d expected 1 0 16", full, empty, count); end
  endtask

  task automatic test_overflow();
    wr_en = 1'b1; wr_data = 8'hEE;
    #1;
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL ovf_write write=%b expected 0", write); end
    step();
    wr_en = 1'b0;
    checks++; if (overflow !== 1'b1 || count !== 5'd16 || wr_addr !== 4'd0 || full !== 1'b1) begin
      errors++; $display("FAIL ovf_pulse ov=%b count=%0d wa=%0d full=%b expected 1 16 0 1", overflow, count, wr_addr, full);
    end
    step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle ov=%b expected 0", overflow); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      #1;
      checks++; if (read !== 1'b1 || rd_addr !== 4'(i)) begin errors++; $display("FAIL drain_pop%0d read=%b rd_addr=%0d expected 1 %0d", i, read, rd_addr, i); end
      step();
      checks++; if (rd_valid !== 1'b1 || ram_q !== 8'(i) || count !== 5'(15 - i)) begin
        errors++; $display("FAIL drain_data%0d rv=%b data=%0d count=%0d expected 1 %0d %0d", i, rd_valid, ram_q, count, i, 15 - i);
      end
    end
    rd_en = 1'b0;
    step();
    checks++; if (rd_valid !== 1'b0 || empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL drain_empty rv=%b empty=%b count=%0d expected 0 1 0", rd_valid, empty, count); end
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    #1;
    checks++; if (read !== 1'b0) begin errors++; $display("FAIL unf_read read=%b expected 0", read); end
    step();
    rd_en = 1'b0;
    checks++; if (underflow !== 1'b1 || count !== 5'd0 || rd_addr !== 4'd0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL unf_pulse un=%b count=%0d ra=%0d rv=%b expected 1 0 0 0", underflow, count, rd_addr, rd_valid);
    end
    step();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_one_cycle un=%b expected 0", underflow); end
    // empty with simultaneous push: the pop is rejected, the push proceeds
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h5A;
    #1;
    checks++; if (write !== 1'b1 || read !== 1'b0) begin errors++; $display("FAIL unf_dual_strobes write=%b read=%b expected 1 0", write, read); end
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (underflow !== 1'b1 || count !== 5'd1 || empty !== 1'b0 || wr_addr !== 4'd1) begin
      errors++; $display("FAIL unf_dual un=%b count=%0d empty=%b wa=%0d expected 1 1 0 1", underflow, count, empty, wr_addr);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    push_n(16, 32);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hFF;
    #1;
    checks++; if (write !== 1'b0 || read !== 1'b1) begin errors++; $display("FAIL fullpop_strobes write=%b read=%b expected 0 1", write, read); end
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (overflow !== 1'b1 || count !== 5'd15 || full !== 1'b0 || rd_addr !== 4'd1 || wr_addr !== 4'd0) begin
      errors++; $display("FAIL fullpop_state ov=%b count=%0d full=%b ra=%0d wa=%0d expected 1 15 0 1 0", overflow, count, full, rd_addr, wr_addr);
    end
    checks++; if (rd_valid !== 1'b1 || ram_q !== 8'd32) begin errors++; $display("FAIL fullpop_data rv=%b data=%0d expected 1 32", rd_valid, ram_q); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_n(5, 0);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'd5;
    #1;
    checks++; if (write !== 1'b1 || read !== 1'b1 || wr_addr !== 4'd5 || rd_addr !== 4'd0) begin
      errors++; $display("FAIL b2b_strobes w=%b r=%b wa=%0d ra=%0d expected 1 1 5 0", write, read, wr_addr, rd_addr);
    end
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (count !== 5'd5 || wr_addr !== 4'd6 || rd_addr !== 4'd1 || rd_valid !== 1'b1 || ram_q !== 8'd0) begin
      errors++; $display("FAIL b2b_state count=%0d wa=%0d ra=%0d rv=%b data=%0d expected 5 6 1 1 0", count, wr_addr, rd_addr, rd_valid, ram_q);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_q [$];
    int         pushes = 0;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      wr_en = (i < 20);
      rd_en = (i >= 4);
      wr_data = 8'(100 + i);
      #1;
      if (i < 20) begin
        checks++; if (wr_addr !== 4'(pushes % 16)) begin errors++; $display("FAIL wrap_addr%0d wr_addr=%0d expected %0d", i, wr_addr, pushes % 16); end
        exp_q.push_back(wr_data);
        pushes++;
      end
      step();
      if (i >= 4) begin
        checks++; if (rd_valid !== 1'b1 || ram_q !== exp_q[0]) begin errors++; $display("FAIL wrap_data%0d rv=%b data=%0d expected 1 %0d", i, rd_valid, ram_q, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (empty !== 1'b1 || wr_addr !== 4'd4 || rd_addr !== 4'd4) begin errors++; $display("FAIL wrap_end empty=%b wa=%0d ra=%0d expected 1 4 4", empty, wr_addr, rd_addr); end
  endtask

`ifdef ALMOST_FLAGS_EN
  task automatic test_almost();
    do_reset();
    push_n(13, 0);
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL af_13 af=%b expected 0", almost_full); end
    push_n(1, 13);
    checks++; if (almost_full !== 1'b1 || count !== 5'd14) begin errors++; $display("FAIL af_14 af=%b count=%0d expected 1 14", almost_full, count); end
    rd_en = 1'b1;
    for (int i = 0; i < 11; i++) step();
    rd_en = 1'b0;
    checks++; if (almost_empty !== 1'b0 || count !== 5'd3) begin errors++; $display("FAIL ae_3 ae=%b count=%0d expected 0 3", almost_empty, count); end
    rd_en = 1'b1; step(); rd_en = 1'b0;
    checks++; if (almost_empty !== 1'b1 || count !== 5'd2) begin errors++; $display("FAIL ae_2 ae=%b count=%0d expected 1 2", almost_empty, count); end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    push_n(6, 0);
    rd_en = 1'b1;
    step();
    rst = 1'b1; wr_en = 1'b1;
    #1;
    checks++; if (write !== 1'b0 || read !== 1'b0) begin errors++; $display("FAIL rstmid_strobes write=%b read=%b expected 0 0", write, read); end
    step();
    checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || wr_addr !== 4'd0 || rd_addr !== 4'd0) begin
      errors++; $display("FAIL rstmid_state count=%0d empty=%b full=%b wa=%0d ra=%0d expected 0 1 0 0 0", count, empty, full, wr_addr, rd_addr);
    end
    checks++; if (rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL rstmid_pulses rv=%b ov=%b un=%b expected 0 0 0", rd_valid, overflow, underflow); end
`ifdef ALMOST_FLAGS_EN
    checks++; if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin errors++; $display("FAIL rstmid_almost af=%b ae=%b expected 0 1", almost_full, almost_empty); end
`endif
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    step();
    checks++; if (rd_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL rstmid_after rv=%b count=%0d expected 0 0", rd_valid, count); end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_full_pop();
    test_back_to_back();
    test_wrap();
`ifdef ALMOST_FLAGS_EN
    test_almost();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
